// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - iterative mult/multu/div/divu unit owning the HI/LO pair
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   start, op           issue request (sampled in IDLE); 00 mult, 01 multu, 10 div, 11 divu
//   inA, inB            multiplicand/dividend, multiplier/divisor
//   cancel              flush the in-flight operation
//   hi_we, lo_we, wdata mthi/mtlo writes, honoured only in IDLE
//   busy, done          operation in flight; one-cycle completion pulse
//   hi, lo              architectural HI/LO registers
module muldiv_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] inA,
  input  logic [WIDTH-1:0] inB,
  input  logic             cancel,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [1:0]         op_r;
  logic               sign_a;
  logic               sign_b;
  logic [WIDTH-1:0]   opa;   // multiplicand, or dividend shifted out MSB-first
  logic [WIDTH-1:0]   opb;   // multiplier shifted out LSB-first, or divisor
  logic [2*WIDTH-1:0] acc;   // product, or {remainder, quotient}

  // Operand capture: signed ops take magnitudes and remember the signs.
  logic             in_signed;
  logic             neg_a;
  logic             neg_b;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;

  assign in_signed = ~op[0];
  assign neg_a     = in_signed & inA[WIDTH-1];
  assign neg_b     = in_signed & inB[WIDTH-1];
  assign abs_a     = neg_a ? (~inA + 1'b1) : inA;
  assign abs_b     = neg_b ? (~inB + 1'b1) : inB;

  // Multiply step: conditional add into the upper half, then shift the
  // 65-bit {carry, acc} right by one.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;

  assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (opb[0] ? {1'b0, opa} : {(WIDTH+1){1'b0}});
  assign mul_next = {mul_sum, acc[WIDTH-1:1]};

  // Divide step: the shifted remainder can reach 2*divisor-1, so it needs
  // one extra bit, and the trial subtract one more for the borrow.
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH+1:0]   diff;
  logic               fits;
  logic [WIDTH-1:0]   rem_next;
  logic [2*WIDTH-1:0] div_next;

  assign rem_sh   = {acc[2*WIDTH-1:WIDTH], opa[WIDTH-1]};
  assign diff     = {1'b0, rem_sh} - {2'b00, opb};
  assign fits     = ~diff[WIDTH+1];
  assign rem_next = fits ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
  assign div_next = {rem_next, acc[WIDTH-2:0], fits};

  // Sign correction applied in FIX.
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  assign prod_fix = (sign_a ^ sign_b) ? (~acc + 1'b1) : acc;
  assign quo_fix  = (sign_a ^ sign_b) ? (~acc[WIDTH-1:0] + 1'b1) : acc[WIDTH-1:0];
  assign rem_fix  = sign_a ? (~acc[2*WIDTH-1:WIDTH] + 1'b1) : acc[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      op_r   <= '0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      opa    <= '0;
      opb    <= '0;
      acc    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (hi_we) hi <= wdata;
          if (lo_we) lo <= wdata;
          // cancel in IDLE has no effect except to drop a simultaneous start
          if (start && !cancel) begin
            op_r   <= op;
            sign_a <= neg_a;
            sign_b <= neg_b;
            opa    <= abs_a;
            opb    <= abs_b;
            acc    <= '0;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= CALC;
          end
        end
        CALC: begin
          if (cancel) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            if (op_r[1]) begin
              acc <= div_next;
              opa <= {opa[WIDTH-2:0], 1'b0};
            end else begin
              acc <= mul_next;
              opb <= {1'b0, opb[WIDTH-1:1]};
            end
            cnt <= cnt + 1'b1;
            if (&cnt) state <= FIX;
          end
        end
        FIX: begin
          busy  <= 1'b0;
          state <= IDLE;
          if (!cancel) begin
            done <= 1'b1;
            if (op_r[1]) begin
              hi <= rem_fix;
              lo <= quo_fix;
            end else begin
              hi <= prod_fix[2*WIDTH-1:WIDTH];
              lo <= prod_fix[WIDTH-1:0];
            end
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Iterative multiply/divide unit for the MIPS-style core. Executes mult, multu, div and divu, and owns the HI/LO register pair.
- Sequences one internal 32-bit add/sub step per cycle: shift-add for multiply, restoring subtract for divide.
- Sits beside the ALU in the execute stage. Decode issues `start`; the pipeline stalls on `busy`; mfhi/mflo read `hi`/`lo`.

Parameters:
- WIDTH, 32, operand, HI and LO width.
- CNT_W, 5, iteration counter width; must satisfy 2^CNT_W = WIDTH.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous reset, active low.
- start  in  1  request a new operation; sampled only in IDLE.
- op  in  2  00 mult, 01 multu, 10 div, 11 divu; sampled with start.
- inA  in  WIDTH  multiplicand / dividend (rs).
- inB  in  WIDTH  multiplier / divisor (rt).
- cancel  in  1  exception flush; abort the in-flight operation.
- hi_we  in  1  mthi write strobe.
- lo_we  in  1  mtlo write strobe.
- wdata  in  WIDTH  mthi/mtlo data.
- busy  out  1  operation in flight (CALC or FIX).
- done  out  1  one-cycle pulse; hi/lo hold the new result.
- hi  out  WIDTH  HI register (product high word / remainder).
- lo  out  WIDTH  LO register (product low word / quotient).

Behaviour:
- Reset (async, rst_n=0): state=IDLE, counter=0, busy=0, done=0, hi=0, lo=0, all internal operand registers 0. Reset asserted mid-operation discards the operation immediately; no done pulse.
- States: IDLE, CALC, FIX.
- IDLE, start=1 at edge N:
  - Capture op.
  - Signed ops (mult, div): capture |inA| and |inB|, plus sign flags sA=inA[31] and sB=inB[31].
  - Unsigned ops: capture inA and inB raw, sign flags 0.
  - Clear the 2*WIDTH accumulator, counter=0, go to CALC, busy=1.
- CALC: one iteration per edge, 32 iterations (edges N+1..N+32). Transition to FIX at the edge where counter==31.
  - Multiply: if multiplier LSB=1, add multiplicand into the upper half with a 33-bit carry. Shift {carry, acc} right 1.
  - Divide: shift {rem, quo} left 1, then trial-subtract the divisor from rem (33-bit). If non-negative, commit the subtraction and set quo[0]=1; else restore.
- FIX, edge N+33:
  - Apply sign correction, write hi/lo, done<=1, busy<=0, state to IDLE.
  - mult: if sA^sB, negate the 64-bit product.
  - div: quotient negated if sA^sB; remainder takes the sign of the dividend (sA).
  - Total latency: start at edge N gives done high during the cycle after edge N+33. busy is high across edges N+1..N+33.
- Divide by zero (divisor==0, div or divu): iterate normally; no special path. Result is lo=32'hFFFF_FFFF (divu) and hi=dividend.
  - For div, the same raw result is sign-fixed per the FIX rules. Bench checks the divu case only.
- div 0x8000_0000 / 0xFFFF_FFFF: lo=0x8000_0000, hi=0 (wraps; no trap).
- start while busy: ignored; op and operands are not re-captured.
- start in the cycle done is high (state already IDLE): accepted normally.
- cancel while busy: next edge state=IDLE, busy=0, no done, hi/lo unchanged. cancel in IDLE: no effect. cancel and start together in IDLE: cancel wins, start dropped.
- hi_we/lo_we:
  - In IDLE: write wdata to hi/lo at the edge.
  - While busy: ignored.
  - In the FIX cycle: the FIX write wins.
- done is registered and never high for two consecutive cycles.
- hi/lo change only on FIX, mthi/mtlo in IDLE, or reset.

Test Plan:
- Reset, multu 0xFFFF_FFFF × 0xFFFF_FFFF -> done exactly 34 cycles after the start edge; hi=0xFFFF_FFFE, lo=0x0000_0001; busy high for 33 cycles.
- mult 0xFFFF_FFFD (-3) × 5 -> hi=0xFFFF_FFFF, lo=0xFFFF_FFF1; then div -7/2 -> lo=0xFFFF_FFFD, hi=0xFFFF_FFFF.
- divu 100/7 -> lo=0x0000_000E, hi=0x0000_0002; divu 5/0 -> lo=0xFFFF_FFFF, hi=0x0000_0005; div 0x8000_0000/-1 -> lo=0x8000_0000, hi=0.
- Start divu 9/2, pulse cancel at iteration 10 -> busy drops the next edge, no done, hi/lo keep prior values. Re-issue divu 9/2 -> lo=4, hi=1.
- During busy: start with new operands, plus mthi 0x1234 -> both ignored, result matches the original op. In IDLE: mtlo 0xABCD -> lo=0xABCD the next cycle.
- Back-to-back: start asserted in the done cycle -> second op accepted, second done exactly 34 cycles later. Async rst_n pulse mid-CALC -> immediate busy=0, hi=lo=0.
